// File: rtl/screen_draw_sequencer_if.sv
// Request, drawer and VGA-side signals of the screen draw sequencer.
// The sequencer uses the slave modport; the environment around it uses master.
interface screen_draw_sequencer_if #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2
);
    logic                   req_valid;
    logic [SEL_W-1:0]       req_sel;
    logic                   req_ready;
    logic [NUM_SRC-1:0]     src_resetn;
    logic [8*NUM_SRC-1:0]   src_x;
    logic [7*NUM_SRC-1:0]   src_y;
    logic [9*NUM_SRC-1:0]   src_colour;
    logic [NUM_SRC-1:0]     src_done;
    logic [7:0]             vga_x;
    logic [6:0]             vga_y;
    logic [8:0]             vga_colour;
    logic                   vga_plot;
    logic                   busy;
    logic                   frame_done;
    logic                   error;

    modport slave (
        input  req_valid, req_sel, src_x, src_y, src_colour, src_done,
        output req_ready, src_resetn, vga_x, vga_y, vga_colour, vga_plot,
               busy, frame_done, error
    );

    modport master (
        output req_valid, req_sel, src_x, src_y, src_colour, src_done,
        input  req_ready, src_resetn, vga_x, vga_y, vga_colour, vga_plot,
               busy, frame_done, error
    );
endinterface

// File: rtl/screen_draw_sequencer.sv
// Runs one selected drawer at a time: releases it from reset, forwards its
// pixel stream to the VGA port, and aborts it if done never arrives.
module screen_draw_sequencer #(
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = 2,
    parameter int TIMEOUT = 20000,
    parameter int CNT_W   = 15
) (
    input  logic                    clk,
    input  logic                    reset,
    screen_draw_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RELEASE = 3'd1,
        S_WAIT    = 3'd2,
        S_PLOT    = 3'd3,
        S_FINISH  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_next;
    logic [CNT_W-1:0]   r_wd;
    logic [CNT_W-1:0]   w_wd_next;
    logic               r_err;
    logic               w_err_next;
    logic               w_sel_ok;
    logic               w_done_sel;
    logic               w_running;

    // Next-state decode, drawer reset release and pixel forwarding
    always_comb begin
        w_state_next    = r_state;
        w_sel_next      = r_sel;
        w_wd_next       = r_wd;
        w_err_next      = r_err;
        w_sel_ok        = ({1'b0, bus.req_sel} < (SEL_W + 1)'(NUM_SRC));
        w_done_sel      = 1'b0;
        w_running       = (r_state == S_RELEASE) || (r_state == S_WAIT) ||
                          (r_state == S_PLOT);
        bus.req_ready   = 1'b0;
        bus.busy        = 1'b1;
        bus.src_resetn  = '0;
        bus.vga_plot    = 1'b0;
        bus.vga_x       = 8'd0;
        bus.vga_y       = 7'd0;
        bus.vga_colour  = 9'd0;
        bus.frame_done  = 1'b0;
        bus.error       = 1'b0;

        // Only the latched source is released, watched and forwarded
        for (int i = 0; i < NUM_SRC; i++) begin
            if (int'(r_sel) == i) begin
                bus.src_resetn[i] = w_running;
                w_done_sel        = bus.src_done[i];
                if (r_state == S_PLOT) begin
                    bus.vga_x      = bus.src_x[8*i +: 8];
                    bus.vga_y      = bus.src_y[7*i +: 7];
                    bus.vga_colour = bus.src_colour[9*i +: 9];
                end else begin
                    bus.vga_x      = 8'd0;
                end
            end else begin
                bus.src_resetn[i] = 1'b0;
            end
        end

        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                bus.busy      = 1'b0;
                if (bus.req_valid) begin
                    w_sel_next   = bus.req_sel;
                    w_err_next   = !w_sel_ok;
                    w_state_next = w_sel_ok ? S_RELEASE : S_FINISH;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                w_state_next = S_PLOT;
                w_wd_next    = '0;
            end
            S_PLOT: begin
                bus.vga_plot = 1'b1;
                w_wd_next    = r_wd + CNT_W'(1);
                // done wins over the watchdog when both land on the same cycle
                if (w_done_sel) begin
                    w_state_next = S_FINISH;
                    w_err_next   = 1'b0;
                end else if (r_wd == CNT_W'(TIMEOUT - 1)) begin
                    w_state_next = S_FINISH;
                    w_err_next   = 1'b1;
                end else begin
                    w_state_next = S_PLOT;
                end
            end
            S_FINISH: begin
                bus.frame_done = 1'b1;
                bus.error      = r_err;
                w_state_next   = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State, latched select, watchdog and abort flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sel   <= '0;
            r_wd    <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_wd    <= w_wd_next;
            r_err   <= w_err_next;
        end
    end
endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Bench for screen_draw_sequencer: two instances (full-size and a 3-source,
// short-watchdog one) driven by contract-following drawer stubs.
module tb_screen_draw_sequencer;
    localparam logic [32:0] IDLE_VEC = 33'h1_0000_0000;

    typedef struct {
        int d; int sel; int len; int plots;
        bit err; bit inv; bit keep; int nsel; bit wiggle;
    } vec_t;

    logic clk;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;

    screen_draw_sequencer_if #(.NUM_SRC(4), .SEL_W(2)) ifa ();
    screen_draw_sequencer_if #(.NUM_SRC(3), .SEL_W(2)) ifb ();

    screen_draw_sequencer #(.NUM_SRC(4), .SEL_W(2), .TIMEOUT(20000), .CNT_W(15))
        dut_a (.clk(clk), .reset(reset), .bus(ifa));
    screen_draw_sequencer #(.NUM_SRC(3), .SEL_W(2), .TIMEOUT(50), .CNT_W(6))
        dut_b (.clk(clk), .reset(reset), .bus(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drawer stubs: [instance][source]; len 0 means done never rises
    logic        rn    [2][4];
    logic        armed [2][4];
    logic        dn    [2][4];
    int          cnt   [2][4];
    int          len   [2][4];
    logic [23:0] p;

    // Raster-order pixel k of a drawer; colour is tagged by source and instance
    function automatic logic [23:0] pix(input int d, input int s, input int k);
        logic [7:0] x;
        logic [6:0] y;
        logic [8:0] c;
        x = 8'(k % 160);
        y = 7'(k / 160);
        c = 9'((k * 5 + s * 97 + d * 31) % 512);
        return {x, y, c};
    endfunction

    always_comb begin
        for (int d = 0; d < 2; d++)
            for (int s = 0; s < 4; s++) rn[d][s] = 1'b0;
        for (int s = 0; s < 4; s++) rn[0][s] = ifa.src_resetn[s];
        for (int s = 0; s < 3; s++) rn[1][s] = ifb.src_resetn[s];
    end

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            for (int s = 0; s < 4; s++) begin
                if (!rn[d][s]) begin
                    armed[d][s] <= 1'b0;
                    cnt[d][s]   <= 0;
                    dn[d][s]    <= 1'b0;
                end else if (!armed[d][s]) begin
                    armed[d][s] <= 1'b1;
                end else if (!dn[d][s]) begin
                    cnt[d][s] <= cnt[d][s] + 1;
                    if (len[d][s] != 0 && cnt[d][s] + 1 == len[d][s]) dn[d][s] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        p = 24'd0;
        ifa.src_x = '0; ifa.src_y = '0; ifa.src_colour = '0; ifa.src_done = '0;
        ifb.src_x = '0; ifb.src_y = '0; ifb.src_colour = '0; ifb.src_done = '0;
        for (int s = 0; s < 4; s++) begin
            p = (cnt[0][s] == 0) ? 24'd0 : pix(0, s, cnt[0][s] - 1);
            ifa.src_x[8*s +: 8]      = p[23:16];
            ifa.src_y[7*s +: 7]      = p[15:9];
            ifa.src_colour[9*s +: 9] = p[8:0];
            ifa.src_done[s]          = dn[0][s];
        end
        for (int s = 0; s < 3; s++) begin
            p = (cnt[1][s] == 0) ? 24'd0 : pix(1, s, cnt[1][s] - 1);
            ifb.src_x[8*s +: 8]      = p[23:16];
            ifb.src_y[7*s +: 7]      = p[15:9];
            ifb.src_colour[9*s +: 9] = p[8:0];
            ifb.src_done[s]          = dn[1][s];
        end
    end

    function automatic logic [32:0] obs(input int d);
        if (d == 0)
            return {ifa.req_ready, ifa.busy, ifa.src_resetn, ifa.vga_plot, ifa.vga_x,
                    ifa.vga_y, ifa.vga_colour, ifa.frame_done, ifa.error};
        else
            return {ifb.req_ready, ifb.busy, 1'b0, ifb.src_resetn, ifb.vga_plot, ifb.vga_x,
                    ifb.vga_y, ifb.vga_colour, ifb.frame_done, ifb.error};
    endfunction

    // Expected outputs i cycles after the accepting edge, for a frame of p plots
    function automatic logic [32:0] expv(input int d, input int sel, input int i,
                                         input int np, input bit er, input bit inv);
        logic [3:0] r;
        r = 4'd1 << sel;
        if (inv) return (i == 1) ? {1'b0, 1'b1, 4'd0, 1'b0, 24'd0, 1'b1, 1'b1} : IDLE_VEC;
        if (i <= 2)      return {1'b0, 1'b1, r, 1'b0, 24'd0, 2'b00};
        if (i <= 2 + np) return {1'b0, 1'b1, r, 1'b1, pix(d, sel, i - 3), 2'b00};
        if (i == 3 + np) return {1'b0, 1'b1, 4'd0, 1'b0, 24'd0, 1'b1, er};
        return IDLE_VEC;
    endfunction

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic set_req(input int d, input bit v, input int sel);
        if (d == 0) begin
            ifa.req_valid = v;
            ifa.req_sel   = 2'(sel);
        end else begin
            ifb.req_valid = v;
            ifb.req_sel   = 2'(sel);
        end
    endtask

    // Called at a negedge in IDLE with the request already driven
    task automatic do_frame(input int d, input int sel, input int np, input bit er,
                            input bit inv, input bit keep, input int nsel, input bit wiggle);
        int last;
        int fin;
        int nbusy;
        int nplot;
        int nfd;
        logic [32:0] o;
        last  = inv ? 2 : 4 + np;
        fin   = inv ? 1 : 3 + np;
        nbusy = 0; nplot = 0; nfd = 0;
        for (int i = 1; i <= last; i++) begin
            @(negedge clk);
            o = obs(d);
            check($sformatf("cycle d%0d s%0d i%0d", d, sel, i), {31'd0, o},
                  {31'd0, expv(d, sel, i, np, er, inv)});
            nbusy += int'(o[31]);
            nplot += int'(o[26]);
            nfd   += int'(o[1]);
            if (i < fin) begin
                if (wiggle) set_req(d, 1'($urandom % 2), int'($urandom % 4));
                else        set_req(d, 1'b0, 0);
            end else if (i == fin) begin
                if (keep) set_req(d, 1'b1, nsel);
                else      set_req(d, 1'b0, 0);
            end
        end
        check("busy_cycles", 64'(nbusy), 64'(inv ? 1 : np + 3));
        check("plot_cycles", 64'(nplot), 64'(np));
        check("frame_done_count", 64'(nfd), 64'd1);
    endtask

    vec_t tbl[9];

    initial begin
        int d, sel, ln, to, np;
        bit inv, er;
        tbl[0] = '{0, 2, 19200, 19200, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[1] = '{1, 1, 0,     50,    1'b1, 1'b0, 1'b0, 0, 1'b1};
        tbl[2] = '{1, 3, 5,     0,     1'b1, 1'b1, 1'b0, 0, 1'b0};
        tbl[3] = '{1, 0, 50,    50,    1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[4] = '{1, 2, 51,    50,    1'b1, 1'b0, 1'b0, 0, 1'b0};
        tbl[5] = '{1, 1, 1,     1,     1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[6] = '{0, 0, 40,    40,    1'b0, 1'b0, 1'b1, 1, 1'b1};
        tbl[7] = '{0, 1, 25,    25,    1'b0, 1'b0, 1'b0, 0, 1'b0};
        tbl[8] = '{0, 3, 2,     2,     1'b0, 1'b0, 1'b0, 0, 1'b1};

        for (int a = 0; a < 2; a++)
            for (int s = 0; s < 4; s++) len[a][s] = 1;
        reset = 1'b1;
        set_req(0, 1'b0, 0);
        set_req(1, 1'b0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_a", {31'd0, obs(0)}, {31'd0, IDLE_VEC});
        check("reset_b", {31'd0, obs(1)}, {31'd0, IDLE_VEC});

        for (int r = 0; r < 9; r++) begin
            len[tbl[r].d][tbl[r].sel] = tbl[r].len;
            set_req(tbl[r].d, 1'b1, tbl[r].sel);
            do_frame(tbl[r].d, tbl[r].sel, tbl[r].plots, tbl[r].err, tbl[r].inv,
                     tbl[r].keep, tbl[r].nsel, tbl[r].wiggle);
        end

        // Reset in the middle of a frame, then a clean restart from pixel 0
        len[0][2] = 300;
        set_req(0, 1'b1, 2);
        @(negedge clk);
        set_req(0, 1'b0, 0);
        repeat (102) @(negedge clk);
        check("pre_reset_pixel100", {31'd0, obs(0)}, {31'd0, expv(0, 2, 103, 300, 1'b0, 1'b0)});
        reset = 1'b1;
        @(negedge clk);
        check("reset_mid_frame", {31'd0, obs(0)}, {31'd0, IDLE_VEC});
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_idle", {31'd0, obs(0)}, {31'd0, IDLE_VEC});
        set_req(0, 1'b1, 2);
        do_frame(0, 2, 300, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Random frames against the frame-level model
        for (int n = 0; n < 30; n++) begin
            d   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 3));
            ln  = (d == 1) ? int'($urandom_range(0, 70)) : int'($urandom_range(1, 70));
            inv = (d == 1) && (sel >= 3);
            to  = (d == 1) ? 50 : 20000;
            np  = inv ? 0 : ((ln == 0 || ln > to) ? to : ln);
            er  = inv || (np != ln);
            len[d][sel] = ln;
            set_req(d, 1'b1, sel);
            do_frame(d, sel, np, er, inv, 1'b0, 0, 1'($urandom % 2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: summary not reached, applied %0d", n_vec);
        $fatal(1);
    end
endmodule
